// File: rtl/jtgng_objbus_arb_if.sv
// Object-RAM bus bundle shared by the CPU decoder, the object DMA and the
// object RAM port. The arbiter connects through the slave modport. The
// master modport is the view seen from the CPU, DMA and RAM side.
//
// Handshake: the DMA raises bus_req and keeps it high for as long as it wants
// the bus. bus_ack is registered. It rises on the cen6 tick that hands the bus
// to the DMA and falls on the cen6 tick on which bus_req is seen low. The CPU
// side is stalled with cpu_wait: while cpu_wait=1 the CPU must hold cpu_cs,
// cpu_wrn, cpu_addr and cpu_dout stable. An access counts as taken on a cen6
// tick on which cpu_wait=0.
interface jtgng_objbus_arb_if #(
  parameter int AW = 9
);
  logic          cpu_cs;
  logic          cpu_wrn;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_dout;
  logic [7:0]    cpu_din;
  logic          cpu_wait;
  logic          bus_req;
  logic          bus_ack;
  logic [AW-1:0] dma_addr;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_din;
  logic [7:0]    ram_dout;
  logic          overrun;

  modport slave (
    input  cpu_cs, cpu_wrn, cpu_addr, cpu_dout, bus_req, dma_addr, ram_dout,
    output cpu_din, cpu_wait, bus_ack, ram_addr, ram_we, ram_din, overrun
  );

  modport master (
    output cpu_cs, cpu_wrn, cpu_addr, cpu_dout, bus_req, dma_addr, ram_dout,
    input  cpu_din, cpu_wait, bus_ack, ram_addr, ram_we, ram_din, overrun
  );
endinterface

// File: rtl/jtgng_objbus_arb.sv
// Object-RAM bus arbiter between the main CPU and the object DMA.
// The DMA only gets the bus at a CPU access boundary. While the DMA owns the
// bus, one CPU write can be posted. It is flushed to RAM when the DMA lets go.
// All state advances on cen6 ticks only. ram_we is qualified by cen6 at the RAM.
module jtgng_objbus_arb #(
  parameter int          AW      = 9,
  parameter logic [15:0] MAXHOLD = 16'd2048
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cen6,
  jtgng_objbus_arb_if.slave  bus,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    ST_CPU   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DMA   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          bus_ack_q, bus_ack_d;
  logic          buf_full_q, buf_full_d;
  logic [AW-1:0] buf_addr_q, buf_addr_d;
  logic [7:0]    buf_data_q, buf_data_d;
  logic          post_act_q, post_act_d;   // current CPU access is the one already posted
  logic [15:0]   hold_q, hold_d;
  logic          overrun_q, overrun_d;
  logic [7:0]    cpu_din_q, cpu_din_d;

  logic wr_req, rd_req, post_ok;

  assign wr_req  = bus.cpu_cs & ~bus.cpu_wrn;
  assign rd_req  = bus.cpu_cs &  bus.cpu_wrn;
  assign post_ok = wr_req & ~buf_full_q & ~post_act_q;

  // Next-state logic, evaluated only on cen6 ticks
  always_comb begin
    state_d    = state_q;
    buf_full_d = buf_full_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    post_act_d = post_act_q;
    hold_d     = hold_q;
    overrun_d  = overrun_q;
    cpu_din_d  = cpu_din_q;
    if (cen6) begin
      if (!bus.cpu_cs) post_act_d = 1'b0;
      case (state_q)
        ST_CPU: begin
          if (rd_req) cpu_din_d = bus.ram_dout;
          if (bus.bus_req) state_d = bus.cpu_cs ? ST_DRAIN : ST_DMA;
        end
        ST_DRAIN: begin
          // The in-flight access finishes this tick, then the DMA may take over
          if (rd_req) cpu_din_d = bus.ram_dout;
          state_d = bus.bus_req ? ST_DMA : ST_CPU;
        end
        ST_DMA: begin
          hold_d = (hold_q == 16'hFFFF) ? hold_q : hold_q + 16'd1;
          if (hold_d >= MAXHOLD) overrun_d = 1'b1;
          if (post_ok) begin
            buf_full_d = 1'b1;
            buf_addr_d = bus.cpu_addr;
            buf_data_d = bus.cpu_dout;
            post_act_d = 1'b1;
          end
          // A write posted on the release tick still has to be flushed
          if (!bus.bus_req) state_d = (buf_full_q | post_ok) ? ST_FLUSH : ST_CPU;
        end
        ST_FLUSH: begin
          buf_full_d = 1'b0;
          state_d    = ST_CPU;
        end
        default: state_d = ST_CPU;
      endcase
      if (state_d == ST_DMA && state_q != ST_DMA) hold_d = 16'd0;
    end
    bus_ack_d = (state_d == ST_DMA);
  end

  // State and data registers, async active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_CPU;
      bus_ack_q  <= 1'b0;
      buf_full_q <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= 8'h00;
      post_act_q <= 1'b0;
      hold_q     <= 16'd0;
      overrun_q  <= 1'b0;
      cpu_din_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      bus_ack_q  <= bus_ack_d;
      buf_full_q <= buf_full_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
      post_act_q <= post_act_d;
      hold_q     <= hold_d;
      overrun_q  <= overrun_d;
      cpu_din_q  <= cpu_din_d;
    end
  end

  // RAM port mux and CPU stall; everything is driven low while reset is held
  always_comb begin
    bus.ram_addr = '0;
    bus.ram_we   = 1'b0;
    bus.ram_din  = 8'h00;
    bus.cpu_wait = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_CPU, ST_DRAIN: begin
          bus.ram_addr = bus.cpu_addr;
          bus.ram_we   = wr_req;
          bus.ram_din  = bus.cpu_dout;
        end
        ST_DMA: begin
          bus.ram_addr = bus.dma_addr;
          bus.cpu_wait = rd_req | (wr_req & buf_full_q & ~post_act_q);
        end
        ST_FLUSH: begin
          bus.ram_addr = buf_addr_q;
          bus.ram_we   = 1'b1;
          bus.ram_din  = buf_data_q;
          bus.cpu_wait = bus.cpu_cs;
        end
        default: ;
      endcase
    end
  end

  assign bus.bus_ack = bus_ack_q;
  assign bus.overrun = overrun_q;
  assign bus.cpu_din = cpu_din_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_jtgng_objbus_arb.sv
// Directed bench for jtgng_objbus_arb. It includes a small object RAM model
// that logs writes. The DUT is built with MAXHOLD=8.
module tb_jtgng_objbus_arb;

  localparam int AW = 9;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen6 = 1'b0;
  logic [1:0] dbg_state;

  int errors = 0;
  int checks = 0;

  logic [7:0]    mem [0:(1<<AW)-1];
  int            wr_cnt = 0;
  logic [AW-1:0] wr_last_addr = '0;
  logic [7:0]    wr_last_data = 8'h00;

  jtgng_objbus_arb_if #(.AW(AW)) ifc ();

  jtgng_objbus_arb #(.AW(AW), .MAXHOLD(16'd8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cen6      (cen6),
    .bus       (ifc),
    .dbg_state (dbg_state)
  );

  // Clock and RAM model
  always #5 clk = ~clk;

  assign ifc.ram_dout = mem[ifc.ram_addr];

  always @(posedge clk) begin
    if (cen6 && ifc.ram_we) begin
      mem[ifc.ram_addr] <= ifc.ram_din;
      wr_cnt            <= wr_cnt + 1;
      wr_last_addr      <= ifc.ram_addr;
      wr_last_data      <= ifc.ram_din;
    end
  end

  // One cen6 tick followed by an idle clock. Returns 1 ns after the last edge.
  task automatic tick();
    cen6 = 1'b1;
    @(posedge clk); #1;
    cen6 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_set(input logic cs, input logic wrn, input logic [AW-1:0] a, input logic [7:0] d);
    ifc.cpu_cs   = cs;
    ifc.cpu_wrn  = wrn;
    ifc.cpu_addr = a;
    ifc.cpu_dout = d;
  endtask

  initial begin
    int wr_snap;
    for (int i = 0; i < (1<<AW); i++) mem[i] = 8'h00;
    cpu_set(1'b0, 1'b1, 9'h123, 8'hEE);
    ifc.bus_req  = 1'b0;
    ifc.dma_addr = 9'h000;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state",    dbg_state,    2'd0);
    chk("rst_bus_ack",  ifc.bus_ack,  1'b0);
    chk("rst_cpu_wait", ifc.cpu_wait, 1'b0);
    chk("rst_ram_we",   ifc.ram_we,   1'b0);
    chk("rst_ram_addr", ifc.ram_addr, 9'h000);
    chk("rst_ram_din",  ifc.ram_din,  8'h00);
    chk("rst_overrun",  ifc.overrun,  1'b0);
    chk("rst_cpu_din",  ifc.cpu_din,  8'h00);
    rst = 1'b0;
    @(posedge clk); #1;

    // Idle arbitration: write 0x5A to 0x010, then read it back
    cpu_set(1'b1, 1'b0, 9'h010, 8'h5A);
    #1;
    chk("idle_wr_we",   ifc.ram_we,   1'b1);
    chk("idle_wr_addr", ifc.ram_addr, 9'h010);
    chk("idle_wr_din",  ifc.ram_din,  8'h5A);
    chk("idle_wr_wait", ifc.cpu_wait, 1'b0);
    tick();
    chk("idle_wr_cnt",  wr_cnt,       1);
    chk("idle_wr_data", wr_last_data, 8'h5A);
    cpu_set(1'b1, 1'b1, 9'h010, 8'h00);
    #1;
    chk("idle_rd_we",   ifc.ram_we,   1'b0);
    tick();
    chk("idle_rd_din",  ifc.cpu_din,  8'h5A);
    chk("idle_rd_ack",  ifc.bus_ack,  1'b0);
    cpu_set(1'b0, 1'b1, 9'h000, 8'h00);

    // Grant on a free bus, DMA address sweep, release
    ifc.bus_req = 1'b1;
    #1;
    chk("grant_pre_ack", ifc.bus_ack, 1'b0);
    tick();
    chk("grant_ack",   ifc.bus_ack, 1'b1);
    chk("grant_state", dbg_state,   2'd2);
    for (int a = 0; a < 'h180; a++) begin
      ifc.dma_addr = a[AW-1:0];
      #1;
      chk("dma_sweep_addr", ifc.ram_addr, a);
    end
    chk("dma_sweep_we", ifc.ram_we, 1'b0);
    ifc.bus_req = 1'b0;
    tick();
    chk("release_ack",     ifc.bus_ack, 1'b0);
    chk("release_state",   dbg_state,   2'd0);
    chk("release_overrun", ifc.overrun, 1'b0);

    // Grant while a CPU write to 0x020 is in flight
    cpu_set(1'b1, 1'b0, 9'h020, 8'h77);
    ifc.bus_req = 1'b1;
    tick();
    chk("drain_state", dbg_state,    2'd1);
    chk("drain_ack",   ifc.bus_ack,  1'b0);
    chk("drain_we",    ifc.ram_we,   1'b1);
    chk("drain_addr",  ifc.ram_addr, 9'h020);
    chk("drain_wait",  ifc.cpu_wait, 1'b0);
    tick();
    chk("drain_ack_rise",  ifc.bus_ack,  1'b1);
    chk("drain_last_addr", wr_last_addr, 9'h020);
    chk("drain_last_data", wr_last_data, 8'h77);
    cpu_set(1'b0, 1'b1, 9'h000, 8'h00);
    ifc.bus_req = 1'b0;
    tick();
    chk("drain_rel_state", dbg_state, 2'd0);

    // Posted write during DMA, then a second write stalls until the flush
    ifc.bus_req = 1'b1;
    tick();
    cpu_set(1'b1, 1'b0, 9'h1F0, 8'h33);
    #1;
    chk("post1_wait", ifc.cpu_wait, 1'b0);
    wr_snap = wr_cnt;
    tick();
    chk("post1_wait_held", ifc.cpu_wait, 1'b0);
    cpu_set(1'b0, 1'b1, 9'h000, 8'h00);
    tick();
    cpu_set(1'b1, 1'b0, 9'h1F1, 8'h44);
    #1;
    chk("post2_wait", ifc.cpu_wait, 1'b1);
    tick();
    chk("post2_wait_tick", ifc.cpu_wait, 1'b1);
    chk("post2_ack",       ifc.bus_ack,  1'b1);
    chk("post2_we",        ifc.ram_we,   1'b0);
    chk("post2_no_write",  wr_cnt,       wr_snap);
    ifc.bus_req = 1'b0;
    #1;
    chk("post2_wait_rel", ifc.cpu_wait, 1'b1);
    tick();
    chk("flush_state", dbg_state,    2'd3);
    chk("flush_ack",   ifc.bus_ack,  1'b0);
    chk("flush_we",    ifc.ram_we,   1'b1);
    chk("flush_addr",  ifc.ram_addr, 9'h1F0);
    chk("flush_din",   ifc.ram_din,  8'h33);
    chk("flush_wait",  ifc.cpu_wait, 1'b1);
    tick();
    chk("flush_wr_addr", wr_last_addr, 9'h1F0);
    chk("flush_wr_data", wr_last_data, 8'h33);
    chk("after_state",   dbg_state,    2'd0);
    chk("after_wait",    ifc.cpu_wait, 1'b0);
    chk("after_addr",    ifc.ram_addr, 9'h1F1);
    chk("after_we",      ifc.ram_we,   1'b1);
    chk("after_din",     ifc.ram_din,  8'h44);
    tick();
    chk("post2_wr_addr", wr_last_addr, 9'h1F1);
    chk("post2_wr_data", wr_last_data, 8'h44);
    chk("post_mem_1f0",  mem[9'h1F0],  8'h33);
    cpu_set(1'b0, 1'b1, 9'h000, 8'h00);

    // Read stall during DMA
    cpu_set(1'b1, 1'b0, 9'h055, 8'hA5);
    tick();
    cpu_set(1'b0, 1'b1, 9'h000, 8'h00);
    ifc.bus_req  = 1'b1;
    ifc.dma_addr = 9'h17F;
    tick();
    cpu_set(1'b1, 1'b1, 9'h055, 8'h00);
    #1;
    chk("rd_stall_wait", ifc.cpu_wait, 1'b1);
    tick();
    chk("rd_stall_wait2", ifc.cpu_wait, 1'b1);
    chk("rd_stall_din",   ifc.cpu_din,  8'h5A);
    ifc.bus_req = 1'b0;
    tick();
    chk("rd_rel_wait",  ifc.cpu_wait, 1'b0);
    chk("rd_rel_state", dbg_state,    2'd0);
    chk("rd_rel_din",   ifc.cpu_din,  8'h5A);
    tick();
    chk("rd_data", ifc.cpu_din, 8'hA5);
    cpu_set(1'b0, 1'b1, 9'h000, 8'h00);

    // No cen6 tick: nothing advances
    ifc.bus_req = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("nocen_ack",   ifc.bus_ack, 1'b0);
    chk("nocen_state", dbg_state,   2'd0);
    tick();
    chk("nocen_grant", ifc.bus_ack, 1'b1);

    // Overrun after MAXHOLD ticks in DMA, sticky after release
    repeat (7) tick();
    chk("ovr_before", ifc.overrun, 1'b0);
    tick();
    chk("ovr_set", ifc.overrun, 1'b1);
    ifc.bus_req = 1'b0;
    tick();
    chk("ovr_sticky", ifc.overrun, 1'b1);
    chk("ovr_rel_ack", ifc.bus_ack, 1'b0);

    // Reset mid-DMA with the post buffer full
    ifc.bus_req = 1'b1;
    tick();
    cpu_set(1'b1, 1'b0, 9'h0AA, 8'h99);
    tick();
    cpu_set(1'b0, 1'b1, 9'h000, 8'h00);
    wr_snap = wr_cnt;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_ack",     ifc.bus_ack, 1'b0);
    chk("mid_rst_overrun", ifc.overrun, 1'b0);
    chk("mid_rst_state",   dbg_state,   2'd0);
    chk("mid_rst_we",      ifc.ram_we,  1'b0);
    ifc.bus_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("mid_rst_no_flush", wr_cnt,      wr_snap);
    chk("mid_rst_mem",      mem[9'h0AA], 8'h00);
    chk("mid_rst_after",    dbg_state,   2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
